// File: rtl/bus_decoder.sv
// bus_decoder: memory-mapped decoder between the CPU data port and N peripheral slots.
// Optional macro BUS_DECODER_PERF_EN adds access/wait counters at STATUS_ADDRESS+3..+5.
module bus_decoder #(
   parameter int N_SLOTS = 6,
   parameter logic [N_SLOTS*16-1:0] SLOT_BASE =
      {16'h8000, 16'h4000, 16'h2000, 16'h0010, 16'h1000, 16'h0000},
   parameter logic [N_SLOTS*16-1:0] SLOT_LAST =
      {16'h8FFF, 16'h4FFF, 16'h2003, 16'h001F, 16'h1002, 16'h00FF},
   parameter int TIMEOUT = 15,
   parameter logic [15:0] STATUS_ADDRESS = 16'h10F0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           din,
   input  logic [15:0]          address,
   input  logic                 w_en,
   input  logic                 r_en,
   output logic [7:0]           dout,
   output logic                 busy,
   output logic [N_SLOTS-1:0]   s_w_en,
   output logic [N_SLOTS-1:0]   s_r_en,
   input  logic [N_SLOTS*8-1:0] s_dout,
   input  logic [N_SLOTS-1:0]   s_ready,
   output logic                 err_flag,
   input  logic                 err_flag_clr
);

   localparam int IW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
`ifdef BUS_DECODER_PERF_EN
   localparam logic [15:0] STAT_SPAN = 16'd6;
`else
   localparam logic [15:0] STAT_SPAN = 16'd3;
`endif
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic {IDLE, RD} state_t;
   typedef enum logic [1:0] {K_SLOT, K_STAT, K_UNMAP} kind_t;

   state_t state, state_n;
   kind_t kind, kind_n;
   logic [IW-1:0] idx, hit_idx;
   logic [15:0] r_addr, offs, r_offs, err_addr;
   logic [7:0] wcnt, rd_data, stat_byte, err_stat, err_bits;
   logic hit, in_stat, slot_hit, unmapped, go;
   logic accept_rd, rd_fire, timeout;
   logic wr_unmap, rd_unmap, err_set, stat_clr;
   logic [N_SLOTS-1:0] onehot;
   logic unused_din;

   // Write data reaches the slots on a shared bus outside this block.
   assign unused_din = ^din;

   always_comb begin
      hit = 1'b0;
      hit_idx = '0;
      for (int k = N_SLOTS - 1; k >= 0; k--) begin
         if (address >= SLOT_BASE[16*k +: 16] &&
             address <= SLOT_LAST[16*k +: 16]) begin
            hit = 1'b1;
            hit_idx = IW'(k);
         end
      end
   end

   assign offs     = address - STATUS_ADDRESS;
   assign in_stat  = (address >= STATUS_ADDRESS) && (offs < STAT_SPAN);
   assign slot_hit = hit && !in_stat;
   assign unmapped = !hit && !in_stat;
   assign onehot   = N_SLOTS'(1) << hit_idx;

   assign busy = (state == RD) && (kind == K_SLOT) && !s_ready[idx];
   assign go   = !busy && !rst;

   assign s_w_en = (go && slot_hit && w_en) ? onehot : '0;
   assign s_r_en = (go && slot_hit && r_en) ? onehot : '0;

   // A completing read frees the bus, so a new read may be accepted in that cycle.
   assign accept_rd = go && r_en;
   assign timeout   = busy && (wcnt == TO_LAST);
   assign rd_fire   = (state == RD) && (!busy || timeout);

   assign wr_unmap = go && w_en && unmapped;
   assign rd_unmap = accept_rd && unmapped;
   assign err_set  = wr_unmap || rd_unmap || timeout;
   assign err_bits = {5'b0, wr_unmap, timeout, wr_unmap || rd_unmap};
   assign stat_clr = go && w_en && in_stat && (offs == 16'd0);

   always_comb begin
      state_n = state;
      kind_n  = kind;
      if (accept_rd) begin
         state_n = RD;
         kind_n  = in_stat ? K_STAT : (hit ? K_SLOT : K_UNMAP);
      end else if (rd_fire) begin
         state_n = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

`ifdef BUS_DECODER_PERF_EN
   logic [15:0] acc_cnt;
   logic [7:0]  wait_cnt;
   logic [16:0] acc_sum;
   logic        perf_clr;

   assign acc_sum  = {1'b0, acc_cnt} + 17'(go && slot_hit && w_en)
                   + 17'(go && slot_hit && r_en);
   assign perf_clr = go && w_en && in_stat && (offs == 16'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_cnt  <= '0;
         wait_cnt <= '0;
      end else if (perf_clr) begin
         acc_cnt  <= '0;
         wait_cnt <= '0;
      end else begin
         acc_cnt <= acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
         if (busy && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
      end
   end
`endif

   assign r_offs = r_addr - STATUS_ADDRESS;

   always_comb begin
      stat_byte = 8'hFF;
      case (r_offs)
         16'd0:   stat_byte = err_stat;
         16'd1:   stat_byte = err_addr[7:0];
         16'd2:   stat_byte = err_addr[15:8];
`ifdef BUS_DECODER_PERF_EN
         16'd3:   stat_byte = acc_cnt[7:0];
         16'd4:   stat_byte = acc_cnt[15:8];
         16'd5:   stat_byte = wait_cnt;
`endif
         default: stat_byte = 8'hFF;
      endcase
   end

   always_comb begin
      rd_data = 8'hFF;
      if (kind == K_SLOT && !timeout) rd_data = s_dout[8*idx +: 8];
      else if (kind == K_STAT)        rd_data = stat_byte;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx    <= '0;
         r_addr <= '0;
         kind   <= K_UNMAP;
         wcnt   <= '0;
         dout   <= 8'h00;
      end else begin
         if (accept_rd) begin
            idx    <= hit_idx;
            r_addr <= address;
            kind   <= kind_n;
            wcnt   <= '0;
         end else if (busy && !timeout) begin
            wcnt <= wcnt + 8'd1;
         end
         if (rd_fire) dout <= rd_data;
      end
   end

   // Only the first error is captured; later ones just mark overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_flag <= 1'b0;
         err_stat <= '0;
         err_addr <= '0;
      end else if (stat_clr) begin
         err_flag <= 1'b0;
         err_stat <= '0;
         err_addr <= '0;
      end else if (err_set) begin
         err_flag <= 1'b1;
         if (!err_flag) begin
            err_stat <= err_bits;
            err_addr <= timeout ? r_addr : address;
         end else begin
            err_stat[7] <= 1'b1;
         end
      end else if (err_flag_clr) begin
         err_flag <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bus_decoder.sv
// tb_bus_decoder: directed self-checking bench for bus_decoder.
// Covers decode, wait states, timeout, error capture and status registers.
module tb_bus_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  din;
   logic [15:0] address;
   logic        w_en, r_en;
   logic [7:0]  dout;
   logic        busy;
   logic [5:0]  s_w_en, s_r_en, s_ready;
   logic [47:0] s_dout;
   logic        err_flag, err_flag_clr;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bus_decoder dut (
      .clk(clk), .rst(rst), .din(din), .address(address),
      .w_en(w_en), .r_en(r_en), .dout(dout), .busy(busy),
      .s_w_en(s_w_en), .s_r_en(s_r_en), .s_dout(s_dout),
      .s_ready(s_ready), .err_flag(err_flag), .err_flag_clr(err_flag_clr)
   );

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_read(input logic [15:0] a);
      address = a;
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      tick();
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d);
      address = a;
      din = d;
      w_en = 1'b1;
      tick();
      w_en = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; w_en = 1'b0; r_en = 1'b1; din = 8'h00;
      address = 16'h1001; s_ready = 6'h3F; s_dout = '0; err_flag_clr = 1'b0;
      @(negedge clk); #1;
      tests++; if (dout !== 8'h00) begin fails++; $display("FAIL rst_dout: got %h want 00", dout); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
      tests++; if (s_r_en !== 6'b0) begin fails++; $display("FAIL rst_s_r_en: got %b want 000000", s_r_en); end
      tests++; if (s_w_en !== 6'b0) begin fails++; $display("FAIL rst_s_w_en: got %b want 000000", s_w_en); end
      tests++; if (err_flag !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err_flag); end
      r_en = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_read;
      s_ready = 6'h3F;
      s_dout[15:8] = 8'h5A;
      address = 16'h1001;
      r_en = 1'b1;
      #1;
      tests++; if (s_r_en !== 6'b000010) begin fails++; $display("FAIL t1_s_r_en: got %b want 000010", s_r_en); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL t1_busy0: got %b want 0", busy); end
      tick();
      r_en = 1'b0;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL t1_busy1: got %b want 0", busy); end
      tick();
      tests++; if (dout !== 8'h5A) begin fails++; $display("FAIL t1_dout: got %h want 5a", dout); end
   endtask

   task automatic test_wait;
      s_ready = 6'b110111;
      s_dout[31:24] = 8'hC3;
      address = 16'h2001;
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         tests++; if (busy !== 1'b1) begin fails++; $display("FAIL t2_busy[%0d]: got %b want 1", i, busy); end
         tick();
      end
      s_ready[3] = 1'b1;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL t2_busy_drop: got %b want 0", busy); end
      tick();
      tests++; if (dout !== 8'hC3) begin fails++; $display("FAIL t2_dout: got %h want c3", dout); end
      tests++; if (err_flag !== 1'b0) begin fails++; $display("FAIL t2_err: got %b want 0", err_flag); end
   endtask

   task automatic test_timeout;
      int n;
      s_ready[3] = 1'b0;
      address = 16'h2002;
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         n++;
         tick();
      end
      tests++; if (n != 15) begin fails++; $display("FAIL t3_busy_cycles: got %0d want 15", n); end
      tests++; if (dout !== 8'hFF) begin fails++; $display("FAIL t3_dout: got %h want ff", dout); end
      tests++; if (err_flag !== 1'b1) begin fails++; $display("FAIL t3_err: got %b want 1", err_flag); end
      s_ready[3] = 1'b1;
      do_read(16'h10F0);
      tests++; if (dout !== 8'h02) begin fails++; $display("FAIL t3_stat: got %h want 02", dout); end
      do_read(16'h10F1);
      tests++; if (dout !== 8'h02) begin fails++; $display("FAIL t3_addr_lo: got %h want 02", dout); end
      do_read(16'h10F2);
      tests++; if (dout !== 8'h20) begin fails++; $display("FAIL t3_addr_hi: got %h want 20", dout); end
      do_write(16'h10F0, 8'h00);
      tests++; if (err_flag !== 1'b0) begin fails++; $display("FAIL t3_clear: got %b want 0", err_flag); end
   endtask

   task automatic test_unmapped;
      address = 16'h3000; din = 8'h77; w_en = 1'b1;
      #1;
      tests++; if (s_w_en !== 6'b0) begin fails++; $display("FAIL t4_sw0: got %b want 000000", s_w_en); end
      tick();
      address = 16'h3001;
      #1;
      tests++; if (s_w_en !== 6'b0) begin fails++; $display("FAIL t4_sw1: got %b want 000000", s_w_en); end
      tick();
      w_en = 1'b0;
      tests++; if (err_flag !== 1'b1) begin fails++; $display("FAIL t4_err: got %b want 1", err_flag); end
      do_read(16'h10F0);
      tests++; if (dout !== 8'h85) begin fails++; $display("FAIL t4_stat: got %h want 85", dout); end
      do_read(16'h10F1);
      tests++; if (dout !== 8'h00) begin fails++; $display("FAIL t4_addr_lo: got %h want 00", dout); end
      do_read(16'h10F2);
      tests++; if (dout !== 8'h30) begin fails++; $display("FAIL t4_addr_hi: got %h want 30", dout); end
      do_write(16'h10F0, 8'h5C);
      tests++; if (err_flag !== 1'b0) begin fails++; $display("FAIL t4_clr_flag: got %b want 0", err_flag); end
      do_read(16'h10F0);
      tests++; if (dout !== 8'h00) begin fails++; $display("FAIL t4_clr_stat: got %h want 00", dout); end
   endtask

   task automatic test_overlap;
      address = 16'h0010; din = 8'h12; w_en = 1'b1;
      #1;
      tests++; if (s_w_en !== 6'b000001) begin fails++; $display("FAIL t5_overlap: got %b want 000001", s_w_en); end
      tick();
      w_en = 1'b0;
      tests++; if (err_flag !== 1'b0) begin fails++; $display("FAIL t5_no_err: got %b want 0", err_flag); end
      do_write(16'h3000, 8'h01);
      err_flag_clr = 1'b1;
      do_write(16'h3001, 8'h02);
      err_flag_clr = 1'b0;
      tests++; if (err_flag !== 1'b1) begin fails++; $display("FAIL t5_set_wins: got %b want 1", err_flag); end
      err_flag_clr = 1'b1;
      tick();
      err_flag_clr = 1'b0;
      tests++; if (err_flag !== 1'b0) begin fails++; $display("FAIL t5_flag_clr: got %b want 0", err_flag); end
      do_read(16'h10F0);
      tests++; if (dout !== 8'h85) begin fails++; $display("FAIL t5_stat_kept: got %h want 85", dout); end
      do_write(16'h10F0, 8'h00);
   endtask

   task automatic test_back_to_back;
      s_ready = 6'h3F;
      s_dout[7:0] = 8'h11;
      s_dout[15:8] = 8'h22;
      address = 16'h0005;
      r_en = 1'b1;
      tick();
      address = 16'h1001;
      #1;
      tests++; if (s_r_en !== 6'b000010) begin fails++; $display("FAIL b2b_s_r_en: got %b want 000010", s_r_en); end
      tick();
      r_en = 1'b0;
      tests++; if (dout !== 8'h11) begin fails++; $display("FAIL b2b_first: got %h want 11", dout); end
      tick();
      tests++; if (dout !== 8'h22) begin fails++; $display("FAIL b2b_second: got %h want 22", dout); end
      s_dout[15:8] = 8'h44;
      address = 16'h1002; w_en = 1'b1; r_en = 1'b1;
      #1;
      tests++; if (s_w_en !== 6'b000010) begin fails++; $display("FAIL rw_s_w_en: got %b want 000010", s_w_en); end
      tests++; if (s_r_en !== 6'b000010) begin fails++; $display("FAIL rw_s_r_en: got %b want 000010", s_r_en); end
      tick();
      w_en = 1'b0; r_en = 1'b0;
      tick();
      tests++; if (dout !== 8'h44) begin fails++; $display("FAIL rw_dout: got %h want 44", dout); end
   endtask

   task automatic test_perf;
`ifdef BUS_DECODER_PERF_EN
      do_write(16'h10F3, 8'h00);
      s_ready[3] = 1'b0;
      address = 16'h2000;
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      tick();
      tick();
      s_ready[3] = 1'b1;
      tick();
      do_write(16'h1000, 8'h9A);
      do_read(16'h1001);
      do_read(16'h10F3);
      tests++; if (dout !== 8'h03) begin fails++; $display("FAIL perf_acc_lo: got %h want 03", dout); end
      do_read(16'h10F4);
      tests++; if (dout !== 8'h00) begin fails++; $display("FAIL perf_acc_hi: got %h want 00", dout); end
      do_read(16'h10F5);
      tests++; if (dout !== 8'h02) begin fails++; $display("FAIL perf_wait: got %h want 02", dout); end
`else
      do_read(16'h10F3);
      tests++; if (dout !== 8'hFF) begin fails++; $display("FAIL perf_off_dout: got %h want ff", dout); end
      tests++; if (err_flag !== 1'b1) begin fails++; $display("FAIL perf_off_err: got %b want 1", err_flag); end
      do_read(16'h10F0);
      tests++; if (dout !== 8'h01) begin fails++; $display("FAIL perf_off_stat: got %h want 01", dout); end
      do_write(16'h10F0, 8'h00);
`endif
   endtask

   task automatic test_async_reset;
      s_ready[3] = 1'b0;
      address = 16'h2000;
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      tick();
      tick();
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ar_busy_pre: got %b want 1", busy); end
      #2 rst = 1'b1;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ar_busy: got %b want 0", busy); end
      tests++; if (dout !== 8'h00) begin fails++; $display("FAIL ar_dout: got %h want 00", dout); end
      @(negedge clk);
      rst = 1'b0;
      repeat (20) tick();
      tests++; if (err_flag !== 1'b0) begin fails++; $display("FAIL ar_no_err: got %b want 0", err_flag); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ar_idle: got %b want 0", busy); end
      s_ready[3] = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_wait();
      test_timeout();
      test_unmapped();
      test_overlap();
      test_back_to_back();
      test_perf();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
